// File: rtl/axi_xbar_pkg.sv
// Shared constants and types for the AXI read arbiter: slave address map,
// slave index encoding and the arbiter FSM states.
package axi_xbar_pkg;

  localparam int          NUM_MAPPED = 3;
  localparam logic [31:0] SLV_MASK   = 32'hFFFF_0000;
  localparam logic [31:0] SLV_BASE [NUM_MAPPED] = '{32'h0000_0000, 32'h0001_0000, 32'h0002_0000};

  typedef enum logic [1:0] {
    SLV0        = 2'd0,
    SLV1        = 2'd1,
    SLV2        = 2'd2,
    SLV_DEFAULT = 2'd3
  } slv_idx_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_e;

endpackage

// File: rtl/axi_addr_decoder.sv
// Combinational read-address decoder: maps ARADDR onto a mapped slave index,
// anything outside the 64 KiB windows goes to the default slave.
module axi_addr_decoder
  import axi_xbar_pkg::*;
(
  input  logic [31:0] addr_i,
  output slv_idx_e    slv_o
);

  always_comb begin
    slv_o = SLV_DEFAULT;
    for (int i = 0; i < NUM_MAPPED; i++) begin
      if ((addr_i & SLV_MASK) == SLV_BASE[i]) slv_o = slv_idx_e'(i);
    end
  end

endmodule

// File: rtl/axi_read_arbiter.sv
// AR/R arbiter for two masters over NUM_SLAVES mapped slaves plus a default
// slave; round-robin grant, one read outstanding, whole R burst routed back.
module axi_read_arbiter
  import axi_xbar_pkg::*;
#(
  parameter int NUM_SLAVES = 3,
  parameter int ID_W       = 4
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic [ID_W-1:0]       ARID_M    [2],
  input  logic [31:0]           ARADDR_M  [2],
  input  logic [3:0]            ARLEN_M   [2],
  input  logic [1:0]            ARVALID_M,
  output logic [1:0]            ARREADY_M,
  output logic [ID_W-1:0]       RID_M,
  output logic [31:0]           RDATA_M,
  output logic [1:0]            RRESP_M,
  output logic                  RLAST_M,
  output logic [1:0]            RVALID_M,
  input  logic [1:0]            RREADY_M,
  output logic [2*ID_W-1:0]     ARID_S,
  output logic [31:0]           ARADDR_S,
  output logic [3:0]            ARLEN_S,
  output logic [NUM_SLAVES:0]   ARVALID_S,
  input  logic [NUM_SLAVES:0]   ARREADY_S,
  input  logic [2*ID_W-1:0]     RID_S     [NUM_SLAVES+1],
  input  logic [31:0]           RDATA_S   [NUM_SLAVES+1],
  input  logic [1:0]            RRESP_S   [NUM_SLAVES+1],
  input  logic [NUM_SLAVES:0]   RLAST_S,
  input  logic [NUM_SLAVES:0]   RVALID_S,
  output logic [NUM_SLAVES:0]   RREADY_S
);

  localparam int SEL_W = $clog2(NUM_SLAVES + 1);

  state_e            state_q, state_d;
  logic              grant_q, grant_d;
  logic              rr_q, rr_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [ID_W-1:0]   arid_q, arid_d;
  logic [31:0]       araddr_q, araddr_d;
  logic [3:0]        arlen_q, arlen_d;

  logic              win;
  slv_idx_e          dec_slv;
  logic [SEL_W-1:0]  dec_sel;

  // Priority master wins if it is requesting, otherwise the other one.
  assign win = ARVALID_M[rr_q] ? rr_q : ~rr_q;

  axi_addr_decoder u_dec (
    .addr_i (ARADDR_M[win]),
    .slv_o  (dec_slv)
  );

  assign dec_sel = (dec_slv == SLV_DEFAULT) ? SEL_W'(NUM_SLAVES) : SEL_W'(dec_slv);

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q  <= ST_IDLE;
      grant_q  <= 1'b0;
      rr_q     <= 1'b0;
      sel_q    <= '0;
      arid_q   <= '0;
      araddr_q <= '0;
      arlen_q  <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_q     <= rr_d;
      sel_q    <= sel_d;
      arid_q   <= arid_d;
      araddr_q <= araddr_d;
      arlen_q  <= arlen_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_d     = rr_q;
    sel_d    = sel_q;
    arid_d   = arid_q;
    araddr_d = araddr_q;
    arlen_d  = arlen_q;
    case (state_q)
      ST_IDLE: begin
        if (|ARVALID_M) begin
          state_d  = ST_ADDR;
          grant_d  = win;
          sel_d    = dec_sel;
          arid_d   = ARID_M[win];
          araddr_d = ARADDR_M[win];
          arlen_d  = ARLEN_M[win];
        end
      end
      ST_ADDR: begin
        if (ARREADY_S[sel_q]) state_d = ST_DATA;
      end
      ST_DATA: begin
        // Burst ends only on the accepted RLAST beat; the loser gets next priority.
        if (RVALID_S[sel_q] && RREADY_M[grant_q] && RLAST_S[sel_q]) begin
          state_d = ST_IDLE;
          rr_d    = ~grant_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ARREADY_M = '0;
    RVALID_M  = '0;
    ARVALID_S = '0;
    RREADY_S  = '0;
    RID_M     = '0;
    RDATA_M   = '0;
    RRESP_M   = '0;
    RLAST_M   = 1'b0;
    case (state_q)
      ST_ADDR: begin
        ARVALID_S[sel_q]   = 1'b1;
        ARREADY_M[grant_q] = ARREADY_S[sel_q];
      end
      ST_DATA: begin
        RVALID_M[grant_q] = RVALID_S[sel_q];
        RREADY_S[sel_q]   = RREADY_M[grant_q];
        RID_M             = RID_S[sel_q][ID_W-1:0];
        RDATA_M           = RDATA_S[sel_q];
        RRESP_M           = RRESP_S[sel_q];
        RLAST_M           = RLAST_S[sel_q];
      end
      default: ;
    endcase
  end

  assign ARID_S   = {ID_W'(grant_q), arid_q};
  assign ARADDR_S = araddr_q;
  assign ARLEN_S  = arlen_q;

endmodule
